seq_divider: RTL

Sequential restoring divider: the inverse of the team's adder/Vedic-multiplier datapath. It takes an unsigned dividend and divisor and produces quotient and remainder, one quotient bit per clock. A start/busy/done handshake lets it sit behind the multiplier as the divide path of the arithmetic unit.

---
 rtl/div_pkg.sv | 14 +
 rtl/seq_divider_trial_sub.sv | 26 ++
 rtl/seq_divider.sv | 105 ++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state
// encodings and the default operand widths.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DW_DEFAULT = 8;
  localparam int VW_DEFAULT = 4;

endpackage

// File: rtl/seq_divider_trial_sub.sv
// Trial subtractor for one restoring-division step: a - b computed as
// a + ~b + 1 through a ripple chain of full-adder cells. A missing carry
// out of the top cell means the subtraction borrowed (a < b).
module trial_sub #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);

  logic [W:0]   carry;
  logic [W-1:0] b_inv;

  assign b_inv    = ~b;
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign diff[i]      = a[i] ^ b_inv[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b_inv[i]) | (carry[i] & (a[i] ^ b_inv[i]));
  end

  assign borrow = ~carry[W];

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider. Produces one quotient bit per clock with a
// start/busy/done handshake; a zero divisor short-circuits straight to DONE
// with the divide-by-zero flag set and an all-ones quotient.
module seq_divider
  import div_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int VW = VW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic          dz,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder
);

  localparam int          CW   = $clog2(DW);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  state_t        state;
  logic [DW-1:0] q_reg;
  logic [VW:0]   r_reg;   // one guard bit so the shifted partial remainder never overflows
  logic [VW-1:0] d_reg;
  logic [CW-1:0] cnt;

  logic [VW:0]   t_val;
  logic [VW:0]   s_val;
  logic          borrow;
  logic [VW:0]   r_next;
  logic [DW-1:0] q_next;

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  assign t_val = {r_reg[VW-1:0], q_reg[DW-1]};

  trial_sub #(.W(VW + 1)) u_trial_sub (
    .a      (t_val),
    .b      ({1'b0, d_reg}),
    .diff   (s_val),
    .borrow (borrow)
  );

  // Restore on borrow; otherwise keep the difference and emit a 1 quotient bit.
  assign r_next = borrow ? t_val : s_val;
  assign q_next = {q_reg[DW-2:0], ~borrow};

  // Control FSM and datapath registers; outputs are registered here as well.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      dz        <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      q_reg     <= '0;
      r_reg     <= '0;
      d_reg     <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        RUN: begin
          q_reg <= q_next;
          r_reg <= r_next;
          if (cnt == LAST) begin
            quotient  <= q_next;
            remainder <= r_next[VW-1:0];
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        // IDLE, DONE and the unused encoding all wait for a start.
        default: begin
          if (start) begin
            if (divisor != '0) begin
              q_reg <= dividend;
              r_reg <= '0;
              d_reg <= divisor;
              cnt   <= '0;
              done  <= 1'b0;
              dz    <= 1'b0;
              busy  <= 1'b1;
              state <= RUN;
            end else begin
              quotient  <= '1;
              remainder <= '0;
              dz        <= 1'b1;
              done      <= 1'b1;
              busy      <= 1'b0;
              state     <= DONE;
            end
          end
        end
      endcase
    end
  end

endmodule
